// File: rtl/dmem_pkg.sv
// Shared types, funct3 encodings and request legality check for the
// valid/ready data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned variants are load-only; out-of-range words are never legal.
    function automatic logic is_legal(input logic        we,
                                      input logic [2:0]  funct3,
                                      input logic [31:0] addr,
                                      input int unsigned depth);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = !addr[0];
            F3_W:    ok = (addr[1:0] == 2'b00);
            F3_BU:   ok = !we;
            F3_HU:   ok = !we && !addr[0];
            default: ok = 1'b0;
        endcase
        if ({2'b00, addr[31:2]} >= depth) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the 32-bit storage word and right-justified
// core data: write enables/replication for stores, extraction for loads.
module mem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    assign byteSel = rword_i[{addr_lo_i, 3'b000} +: 8];
    assign halfSel = rword_i[{addr_lo_i[1], 4'b0000} +: 16];

    // Store data is replicated across lanes so the enables alone pick the target.
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = 32'h0;
        case (funct3_i)
            F3_B, F3_BU: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            F3_H, F3_HU: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            F3_W: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
            end
            default: begin
                be_o    = 4'b0000;
                wdata_o = 32'h0;
            end
        endcase
    end

    always_comb begin
        rdata_o = 32'h0;
        case (funct3_i)
            F3_B:    rdata_o = {{24{byteSel[7]}}, byteSel};
            F3_BU:   rdata_o = {24'h0, byteSel};
            F3_H:    rdata_o = {{16{halfSel[15]}}, halfSel};
            F3_HU:   rdata_o = {16'h0, halfSel};
            F3_W:    rdata_o = rword_i;
            default: rdata_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: request/response handshakes,
// configurable wait states and error responses for illegal accesses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    input  logic        rsp_ready
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [AW+1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [2:0]      f3_q, f3_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            doWrite;

    logic [31:0]     mem [DEPTH];
    logic [31:0]     rawWord;
    logic [3:0]      byteEn;
    logic [31:0]     laneData;
    logic [31:0]     loadData;

    assign rawWord = mem[addr_q[AW+1:2]];

    mem_lane_align u_align (
        .funct3_i  (f3_q),
        .addr_lo_i (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .rword_i   (rawWord),
        .be_o      (byteEn),
        .wdata_o   (laneData),
        .rdata_o   (loadData)
    );

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        doWrite = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr[AW+1:0];
                    wdata_d = req_wdata;
                    f3_d    = req_funct3;
                    if (!is_legal(req_we, req_funct3, req_addr, 32'(DEPTH))) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CW'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    rdata_d = we_q ? 32'h0 : loadData;
                    doWrite = we_q;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        f3_q    <= f3_d;
    end

    // Storage is never reset; a reset on the access edge suppresses the store.
    always_ff @(posedge clk) begin
        if (doWrite && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) begin
                    mem[addr_q[AW+1:2]][8*i +: 8] <= laneData[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder with WAIT_CYCLES=2, DEPTH=256.
module tb_dmem_responder;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_ready;

    int nChecks = 0;
    int nErrors = 0;

    logic [32:0] sbQ[$];
    int          latQ[$];

    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_ready  (rsp_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one request just after a clock edge and holds it for one edge.
    task automatic applyStimulus(input string tag, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [2:0] f3,
                                 input logic expErr, input logic [31:0] expData);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        check({tag, " req_ready"}, 32'(req_ready), 32'd1);
        sbQ.push_back({expErr, expData});
        latQ.push_back(expErr ? 0 : W + 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Waits (bounded) for the response and compares it to the scoreboard head.
    task automatic checkOutput(input string tag);
        int          n;
        logic [32:0] exp;
        int          expLat;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        exp    = sbQ.pop_front();
        expLat = latQ.pop_front();
        check({tag, " latency"}, 32'(n), 32'(expLat));
        check({tag, " rsp_err"}, 32'(rsp_err), 32'(exp[32]));
        check({tag, " rsp_rdata"}, rsp_rdata, exp[31:0]);
    endtask

    task automatic finishRsp(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({tag, " rsp_valid cleared"}, 32'(rsp_valid), 32'd0);
        check({tag, " back to idle"}, 32'(req_ready), 32'd1);
    endtask

    task automatic transact(input string tag, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [2:0] f3,
                            input logic expErr, input logic [31:0] expData);
        applyStimulus(tag, we, addr, wdata, f3, expErr, expData);
        checkOutput(tag);
        finishRsp(tag);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_funct3 = 3'b000;
        rsp_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_err", 32'(rsp_err), 32'd0);
        check("reset rsp_rdata", rsp_rdata, 32'h0);
        check("reset req_ready", 32'(req_ready), 32'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        transact("sw64", 1'b1, 32'h64, 32'h19, 3'b010, 1'b0, 32'h0);
        transact("lw64", 1'b0, 32'h64, 32'h0, 3'b010, 1'b0, 32'h19);

        transact("sw80", 1'b1, 32'h80, 32'h11223344, 3'b010, 1'b0, 32'h0);
        transact("lb83", 1'b0, 32'h83, 32'h0, 3'b000, 1'b0, 32'h11);
        transact("sb81", 1'b1, 32'h81, 32'hF0, 3'b000, 1'b0, 32'h0);
        transact("lb81", 1'b0, 32'h81, 32'h0, 3'b000, 1'b0, 32'hFFFFFFF0);
        transact("lbu81", 1'b0, 32'h81, 32'h0, 3'b100, 1'b0, 32'h000000F0);
        transact("lw80", 1'b0, 32'h80, 32'h0, 3'b010, 1'b0, 32'h1122F044);

        transact("sw40", 1'b1, 32'h40, 32'h12345678, 3'b010, 1'b0, 32'h0);
        transact("sh42", 1'b1, 32'h42, 32'hBEEF, 3'b001, 1'b0, 32'h0);
        transact("lw40", 1'b0, 32'h40, 32'h0, 3'b010, 1'b0, 32'hBEEF5678);
        transact("lh42", 1'b0, 32'h42, 32'h0, 3'b001, 1'b0, 32'hFFFFBEEF);
        transact("lhu42", 1'b0, 32'h42, 32'h0, 3'b101, 1'b0, 32'h0000BEEF);

        transact("lw66 misaligned", 1'b0, 32'h66, 32'h0, 3'b010, 1'b1, 32'h0);
        transact("sh41 misaligned", 1'b1, 32'h41, 32'h5A5A, 3'b001, 1'b1, 32'h0);
        transact("sw400 range", 1'b1, 32'h400, 32'h77, 3'b010, 1'b1, 32'h0);
        transact("f3 011", 1'b0, 32'h64, 32'h0, 3'b011, 1'b1, 32'h0);
        transact("sbu store", 1'b1, 32'h64, 32'hFF, 3'b100, 1'b1, 32'h0);
        transact("lw64 after errs", 1'b0, 32'h64, 32'h0, 3'b010, 1'b0, 32'h19);

        applyStimulus("lw64 stall", 1'b0, 32'h64, 32'h0, 3'b010, 1'b0, 32'h19);
        checkOutput("lw64 stall");
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 32'h64;
        req_wdata  = 32'hDEAD;
        req_funct3 = 3'b010;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall rsp_rdata", rsp_rdata, 32'h19);
            check("stall rsp_err", 32'(rsp_err), 32'd0);
            check("stall req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        finishRsp("lw64 stall");
        repeat (W + 2) begin
            @(posedge clk);
            #1;
            check("no stray rsp", 32'(rsp_valid), 32'd0);
        end
        transact("lw64 post stall", 1'b0, 32'h64, 32'h0, 3'b010, 1'b0, 32'h19);

        transact("sw20 one", 1'b1, 32'h20, 32'h1, 3'b010, 1'b0, 32'h0);
        transact("lw20 pre", 1'b0, 32'h20, 32'h0, 3'b010, 1'b0, 32'h1);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 32'h20;
        req_wdata  = 32'hAAAA5555;
        req_funct3 = 3'b010;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (W) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort rsp_err", 32'(rsp_err), 32'd0);
        check("abort rsp_rdata", rsp_rdata, 32'h0);
        check("abort req_ready", 32'(req_ready), 32'd1);
        transact("lw20 post abort", 1'b0, 32'h20, 32'h0, 3'b010, 1'b0, 32'h1);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
